// File: rtl/search_32.sv
// search_32: binary-search initiator that locates an unknown value P by
// driving probes into an external three-way magnitude comparator.
// Optional feature macro: SEARCH_STEP_CNT_EN enables the 6-bit probe
// counter on `steps`; when it is undefined, `steps` is tied to zero.
module search_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_pbig,
  input  logic             cmp_same,
  input  logic             cmp_qbig,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [5:0]       steps
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t state, state_nxt;

  // The window bounds carry one extra bit so that lo+hi, probe+1 and
  // probe-1 never wrap.
  logic [WIDTH:0] lo, hi;
  logic [WIDTH:0] sum, mid, probe_ext, probe_inc, probe_dec;
  logic           verdict_ok;
  logic           probe_max, probe_min;

  // Control strobes decoded from the current state and verdict.
  logic clear, take_probe, set_lo, set_hi, set_result, set_error;

  assign sum        = lo + hi;
  assign mid        = sum >> 1;
  assign probe_ext  = {1'b0, probe};
  assign probe_inc  = probe_ext + 1'b1;
  assign probe_dec  = probe_ext - 1'b1;
  assign verdict_ok = $onehot({cmp_pbig, cmp_same, cmp_qbig});
  assign probe_max  = (probe == {WIDTH{1'b1}});
  assign probe_min  = (probe == '0);

  assign busy = (state == LOAD) || (state == CHECK);
  assign done = (state == DONE);

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt  = state;
    clear      = 1'b0;
    take_probe = 1'b0;
    set_lo     = 1'b0;
    set_hi     = 1'b0;
    set_result = 1'b0;
    set_error  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        take_probe = 1'b1;
        state_nxt  = CHECK;
      end
      CHECK: begin
        if (!verdict_ok) begin
          set_error = 1'b1;
          state_nxt = DONE;
        end else if (cmp_same) begin
          set_result = 1'b1;
          state_nxt  = DONE;
        end else if (cmp_pbig) begin
          // P is above the probe: moving lo past hi means the comparator
          // contradicted an earlier verdict.
          if (probe_max || (probe_inc > hi)) begin
            set_error = 1'b1;
            state_nxt = DONE;
          end else begin
            set_lo    = 1'b1;
            state_nxt = LOAD;
          end
        end else begin
          if (probe_min || (lo > probe_dec)) begin
            set_error = 1'b1;
            state_nxt = DONE;
          end else begin
            set_hi    = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and search datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        lo    <= '0;
        hi    <= {1'b0, {WIDTH{1'b1}}};
        error <= 1'b0;
      end
      if (take_probe) probe  <= mid[WIDTH-1:0];
      if (set_lo)     lo     <= probe_inc;
      if (set_hi)     hi     <= probe_dec;
      if (set_result) result <= probe;
      if (set_error)  error  <= 1'b1;
    end
  end

`ifdef SEARCH_STEP_CNT_EN
  // Probe counter: cleared on start, bumped per issued probe, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps <= '0;
    end else if (clear) begin
      steps <= '0;
    end else if (take_probe && (steps != 6'd63)) begin
      steps <= steps + 6'd1;
    end
  end
`else
  assign steps = '0;
`endif

endmodule

// File: tb/tb_search_32.sv
// tb_search_32: randomized self-checking bench for search_32. The bench
// models the external comparator for a chosen P and predicts the probe
// sequence with a plain binary search over 64-bit integers.
module tb_search_32;

`ifdef SEARCH_STEP_CNT_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cmp_pbig, cmp_same, cmp_qbig;
  logic [31:0] probe, result;
  logic        busy, done, error;
  logic [5:0]  steps;

  logic [31:0] p_val = '0;
  int          cmp_mode = 0;  // 0 honest, 1 all-zero verdict, 2 pbig|qbig
  logic [31:0] last_result = '0;

  int n_checks = 0;
  int n_fail = 0;

  search_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_pbig(cmp_pbig), .cmp_same(cmp_same), .cmp_qbig(cmp_qbig),
    .probe(probe), .busy(busy), .done(done), .error(error),
    .result(result), .steps(steps)
  );

  always #5 clk = ~clk;

  // External comparator: combinational on the registered probe.
  always_comb begin
    cmp_pbig = 1'b0;
    cmp_same = 1'b0;
    cmp_qbig = 1'b0;
    case (cmp_mode)
      0: begin
        cmp_pbig = (p_val > probe);
        cmp_same = (p_val == probe);
        cmp_qbig = (p_val < probe);
      end
      2: begin
        cmp_pbig = 1'b1;
        cmp_qbig = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the probes a binary search over [0, 2^32-1] issues for p.
  function automatic void model_probes(input logic [31:0] p, output longint q[$]);
    longint lo = 0;
    longint hi = 64'h0000_0000_FFFF_FFFF;
    longint mid;
    q = {};
    forever begin
      mid = (lo + hi) / 2;
      q.push_back(mid);
      if (mid == longint'(p)) break;
      if (longint'(p) > mid) lo = mid + 1;
      else hi = mid - 1;
    end
  endfunction

  // Runs one search from IDLE/DONE. mode selects comparator behaviour,
  // disturb sprinkles extra start pulses while the search is busy.
  task automatic run_search(input logic [31:0] p, input int mode, input bit disturb);
    longint exp_q[$];
    longint got_q[$];
    int     n_exp, done_cyc;
    logic [31:0] exp_res;
    logic        exp_err;

    p_val    = p;
    cmp_mode = mode;
    if (mode == 0) begin
      model_probes(p, exp_q);
      exp_res = p;
      exp_err = 1'b0;
    end else begin
      exp_q   = {64'h7FFF_FFFF};
      exp_res = last_result;
      exp_err = 1'b1;
    end
    n_exp    = exp_q.size();
    done_cyc = -1;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);  // E0 has passed: state should be LOAD
    start = 1'b0;
    check("after_start_busy", 64'(busy), 64'd1);
    check("after_start_done", 64'(done), 64'd0);

    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc % 2 == 1) got_q.push_back(longint'(probe));
      if (done) begin
        done_cyc = cyc;
        start = 1'b0;
        break;
      end
      start = disturb && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;

    if (done_cyc < 0) begin
      check("timeout", 64'd0, 64'd1);
    end else begin
      check("done_cycle", 64'(done_cyc), 64'(2 * n_exp));
      check("busy_at_done", 64'(busy), 64'd0);
      check("error", 64'(error), 64'(exp_err));
      check("result", 64'(result), 64'(exp_res));
      check("steps", 64'(steps), STEP_EN ? 64'(n_exp) : 64'd0);
      check("probe_count", 64'(got_q.size()), 64'(n_exp));
      for (int i = 0; i < n_exp && i < got_q.size(); i++)
        check($sformatf("probe[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
      // DONE holds its outputs while start stays low.
      @(negedge clk);
      check("done_hold", 64'(done), 64'd1);
      check("probe_hold", 64'(probe), 64'(exp_q[n_exp-1]));
      if (!exp_err) last_result = p;
    end
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_probe", 64'(probe), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_steps", 64'(steps), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed boundaries.
    run_search(32'h7FFF_FFFF, 0, 1'b0);
    run_search(32'h0000_0000, 0, 1'b0);
    run_search(32'hFFFF_FFFF, 0, 1'b0);
    // Protocol violations in the first CHECK: result must stay 0xFFFFFFFF.
    run_search(32'h1234_5678, 1, 1'b0);
    run_search(32'h1234_5678, 2, 1'b0);
    run_search(32'h0000_0001, 2, 1'b1);

    // Asynchronous reset in the middle of a search.
    p_val    = 32'h1234_5678;
    cmp_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_probe", 64'(probe), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_steps", 64'(steps), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_result = '0;
    @(negedge clk);
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    check("post_rst_idle_done", 64'(done), 64'd0);
    run_search(32'h1234_5678, 0, 1'b0);

    // Disturbed and random searches, each restarted from DONE.
    run_search(32'h1234_5678, 0, 1'b1);
    for (int i = 0; i < 12; i++)
      run_search($urandom, 0, i[0]);
    run_search(32'h8000_0000, 0, 1'b1);
    run_search(32'h0000_0001, 0, 1'b1);
    run_search(32'hFFFF_FFFE, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
